// File: rtl/psum_pkg.sv
// Shared types and helpers for the partial-sum write sequencer.
//
// Contents:
//   psum_state_e  - sequencer states (idle, fill, compute, row end, channel end, drain, done)
//   psum_wr_t     - one write-side transaction {en, addr, out} carried through the
//                   accumulator-latency delay line
//   ofm_w/ofm_h   - output feature map dimensions for a valid (no padding, stride 1) conv
package psum_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StCompute,
        StRowEnd,
        StChEnd,
        StDrain,
        StDone
    } psum_state_e;

    // Address field is sized for the widest supported psum buffer; users narrow it.
    localparam int unsigned PsumAddrWMax = 16;

    typedef struct packed {
        logic                    en;
        logic [PsumAddrWMax-1:0] addr;
        logic                    out;
    } psum_wr_t;

    function automatic int unsigned ofm_w(input int unsigned ifm_w, input int unsigned k);
        return ifm_w - k + 1;
    endfunction

    function automatic int unsigned ofm_h(input int unsigned ifm_h, input int unsigned k);
        return ifm_h - k + 1;
    endfunction

endpackage

// File: rtl/psum_wr_seq_delay_line.sv
// psum_delay_line: Depth-stage shift register for write transactions. Aligns the psum
// write strobe/address/output tag with the accumulator pipeline. Shifts every cycle.
//
// Ports:
//   clk2  - clock
//   rst_n - asynchronous active-low reset, clears every stage
//   wr_i  - transaction entering the pipe (the registered read side)
//   wr_o  - transaction leaving the pipe Depth cycles later
module psum_delay_line
    import psum_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic     clk2,
    input  logic     rst_n,
    input  psum_wr_t wr_i,
    output psum_wr_t wr_o
);

    psum_wr_t stage_q [Depth];

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= wr_i;
            for (int i = 1; i < Depth; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign wr_o = stage_q[Depth-1];

endmodule

// File: rtl/psum_wr_seq.sv
// psum_wr_seq: partial-sum write sequencer for the PE-array output path.
// Walks the IFM row by row for each input channel and issues psum SRAM read strobes and
// addresses; write strobes follow the reads through an ACC_LAT-deep delay line.
// The first channel reads as zero (rd_clr), the last channel routes to the output FIFO
// (wr_out).
//
// Optional feature: define PSUM_ABORT_EN to add the 'abort' input, which sends any active
// run straight to DRAIN so in-flight writes retire and done pulses.
//
// Ports:
//   clk2, rst_n        - clock, asynchronous active-low reset
//   start_conv         - start pulse, only honoured in IDLE
//   cfg_num_ch         - channel count captured at start (0 -> 1, clamped to NUM_CH_MAX)
//   pix_valid          - one IFM pixel column processed this cycle
//   abort              - (PSUM_ABORT_EN only) abandon the run
//   rd_en/rd_addr/rd_clr   - psum read strobe, address, first-channel zero select
//   wr_en/wr_addr/wr_out   - psum write strobe, address, last-channel FIFO select
//   busy, done         - run in progress, one-cycle completion pulse
//   ch_idx             - current input channel
// ADDR_W must cover OFM_W*OFM_H addresses and be no wider than PsumAddrWMax.
module psum_wr_seq
    import psum_pkg::*;
#(
    parameter int unsigned NUM_CH_MAX  = 16,
    parameter int unsigned IFM_W       = 9,
    parameter int unsigned IFM_H       = 9,
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned ACC_LAT     = 2,
    parameter int unsigned ADDR_W      = 10
) (
    input  logic                              clk2,
    input  logic                              rst_n,
    input  logic                              start_conv,
    input  logic [$clog2(NUM_CH_MAX+1)-1:0]   cfg_num_ch,
    input  logic                              pix_valid,
`ifdef PSUM_ABORT_EN
    input  logic                              abort,
`endif
    output logic                              rd_en,
    output logic [ADDR_W-1:0]                 rd_addr,
    output logic                              rd_clr,
    output logic                              wr_en,
    output logic [ADDR_W-1:0]                 wr_addr,
    output logic                              wr_out,
    output logic                              busy,
    output logic                              done,
    output logic [$clog2(NUM_CH_MAX)-1:0]     ch_idx
);

    localparam int unsigned CfgW   = $clog2(NUM_CH_MAX + 1);
    localparam int unsigned ChW    = $clog2(NUM_CH_MAX);
    localparam int unsigned ColW   = (IFM_W > 1) ? $clog2(IFM_W) : 1;
    localparam int unsigned RowW   = (IFM_H > 1) ? $clog2(IFM_H) : 1;
    localparam int unsigned DrainW = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;
    localparam int unsigned OfmW   = ofm_w(IFM_W, KERNEL_SIZE);

    // A 1x1 kernel has no rows to pre-fill.
    localparam psum_state_e StFirst = psum_state_e'((KERNEL_SIZE > 1) ? StFill : StCompute);

    psum_state_e         state_q;
    logic [ColW-1:0]     col_q;
    logic [RowW-1:0]     row_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ChW-1:0]      ch_q;
    logic [CfgW-1:0]     num_ch_q;
    logic [DrainW-1:0]   drain_q;
    logic                rd_en_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic                rd_clr_q;
    logic                rd_last_q;
    logic                busy_q;
    logic                done_q;

    logic [CfgW-1:0]     num_ch_cfg;
    logic                col_last;
    logic                row_last;
    logic                last_ch;

    always_comb begin
        num_ch_cfg = cfg_num_ch;
        if (cfg_num_ch == '0) begin
            num_ch_cfg = CfgW'(1);
        end else if (cfg_num_ch > CfgW'(NUM_CH_MAX)) begin
            num_ch_cfg = CfgW'(NUM_CH_MAX);
        end
    end

    assign col_last = (col_q == ColW'(IFM_W - 1));
    assign row_last = (row_q == RowW'(IFM_H - 1));
    assign last_ch  = (CfgW'(ch_q) == (num_ch_q - CfgW'(1)));

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            col_q     <= '0;
            row_q     <= '0;
            addr_q    <= '0;
            ch_q      <= '0;
            num_ch_q  <= '0;
            drain_q   <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_clr_q  <= 1'b0;
            rd_last_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            rd_en_q   <= 1'b0;
            rd_clr_q  <= 1'b0;
            rd_last_q <= 1'b0;
            done_q    <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (start_conv) begin
                        num_ch_q <= num_ch_cfg;
                        busy_q   <= 1'b1;
                        state_q  <= StFirst;
                    end
                end

                // Rows above the first full kernel window: count columns, no strobes.
                StFill: begin
                    if (pix_valid) begin
                        if (col_last) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                            if (row_q == RowW'(KERNEL_SIZE - 2)) begin
                                state_q <= StCompute;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end

                // Only columns with a full kernel window produce an output pixel.
                StCompute: begin
                    if (pix_valid) begin
                        if (col_q >= ColW'(IFM_W - OfmW)) begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= addr_q;
                            rd_clr_q  <= (ch_q == '0);
                            rd_last_q <= last_ch;
                            addr_q    <= addr_q + 1'b1;
                        end
                        if (col_last) begin
                            col_q   <= '0;
                            state_q <= StRowEnd;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end

                StRowEnd: begin
                    row_q   <= row_q + 1'b1;
                    state_q <= row_last ? StChEnd : StCompute;
                end

                StChEnd: begin
                    addr_q <= '0;
                    row_q  <= '0;
                    col_q  <= '0;
                    if (last_ch) begin
                        drain_q <= '0;
                        state_q <= StDrain;
                    end else begin
                        ch_q    <= ch_q + 1'b1;
                        state_q <= StFirst;
                    end
                end

                // Give the delay line ACC_LAT cycles to retire the last writes.
                StDrain: begin
                    if (drain_q == DrainW'(ACC_LAT - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end

                StDone: begin
                    busy_q  <= 1'b0;
                    ch_q    <= '0;
                    drain_q <= '0;
                    state_q <= StIdle;
                end

                default: state_q <= StIdle;
            endcase

`ifdef PSUM_ABORT_EN
            // DRAIN and DONE are already finishing; re-entering DRAIN there would only
            // postpone done. The read that would have issued this cycle is dropped.
            if (abort && (state_q inside {StFill, StCompute, StRowEnd, StChEnd})) begin
                state_q   <= StDrain;
                drain_q   <= '0;
                rd_en_q   <= 1'b0;
                rd_clr_q  <= 1'b0;
                rd_last_q <= 1'b0;
                col_q     <= '0;
                row_q     <= '0;
                addr_q    <= '0;
            end
`endif
        end
    end

    psum_wr_t wr_in;
    psum_wr_t wr_dly;

    always_comb begin
        wr_in      = '0;
        wr_in.en   = rd_en_q;
        wr_in.addr = PsumAddrWMax'(rd_addr_q);
        wr_in.out  = rd_last_q;
    end

    psum_delay_line #(
        .Depth (ACC_LAT)
    ) u_delay_line (
        .clk2  (clk2),
        .rst_n (rst_n),
        .wr_i  (wr_in),
        .wr_o  (wr_dly)
    );

    // Upper address bits beyond ADDR_W are always zero.
    logic unused_wr_addr;
    assign unused_wr_addr = ^wr_dly.addr;

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign rd_clr  = rd_clr_q;
    assign wr_en   = wr_dly.en;
    assign wr_addr = wr_dly.addr[ADDR_W-1:0];
    assign wr_out  = wr_dly.out;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ch_idx  = ch_q;

endmodule
